// File: rtl/fht_sequencer.sv
// Address and control sequencer for an in-place radix-2 fast Hartley transform
// over four banks of D=2^A_BIT points; one pass per stage, butterfly latency WR_LAT.
module fht_sequencer #(
  parameter int unsigned A_BIT  = 8,
  parameter int unsigned WR_LAT = 5
) (
  input  logic             iCLK,
  input  logic             iRESET,
  input  logic             iSTART,
  input  logic             iABORT,
  output logic [A_BIT-1:0] oADDR_RD_0,
  output logic [A_BIT-1:0] oADDR_RD_1,
  output logic [A_BIT-1:0] oADDR_RD_2,
  output logic [A_BIT-1:0] oADDR_RD_3,
  output logic [A_BIT-1:0] oADDR_WR_0,
  output logic [A_BIT-1:0] oADDR_WR_1,
  output logic [A_BIT-1:0] oADDR_WR_2,
  output logic [A_BIT-1:0] oADDR_WR_3,
  output logic [A_BIT-1:0] oADDR_COEF,
  output logic [A_BIT-1:0] oSTAGE,
  output logic [A_BIT-1:0] oSECTOR,
  output logic             oST_ZERO,
  output logic             oST_LAST,
  output logic             o2ND_PART_SUBSEC,
  output logic             oWE_A,
  output logic             oWE_B,
  output logic             oSOURCE_DATA,
  output logic             oRDY,
  output logic             oDONE
);

  localparam int unsigned D      = 2 ** A_BIT;
  localparam int unsigned STAGES = A_BIT + 2;
  localparam int unsigned L      = D + WR_LAT + 1;
  localparam int unsigned T_W    = A_BIT + 1;
  localparam int unsigned S_W    = $clog2(STAGES);
  localparam int unsigned DW     = A_BIT + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state, state_nxt;
  logic [S_W-1:0] s, s_nxt;
  logic [T_W-1:0] t, t_nxt;

  // State register
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      state <= IDLE;
      s     <= '0;
      t     <= '0;
    end else begin
      state <= state_nxt;
      s     <= s_nxt;
      t     <= t_nxt;
    end
  end

  // Next-state: stage/time counters, abort wins in RUN
  always_comb begin
    state_nxt = state;
    s_nxt     = s;
    t_nxt     = t;
    case (state)
      IDLE: begin
        if (iSTART) begin
          state_nxt = RUN;
          s_nxt     = '0;
          t_nxt     = '0;
        end
      end
      RUN: begin
        if (iABORT) begin
          state_nxt = IDLE;
          s_nxt     = '0;
          t_nxt     = '0;
        end else if (t == T_W'(L - 1)) begin
          t_nxt = '0;
          if (s == S_W'(STAGES - 1)) begin
            state_nxt = DONE;
            s_nxt     = '0;
          end else begin
            s_nxt = s + 1'b1;
          end
        end else begin
          t_nxt = t + 1'b1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
        s_nxt     = '0;
        t_nxt     = '0;
      end
      default: begin
        state_nxt = IDLE;
        s_nxt     = '0;
        t_nxt     = '0;
      end
    endcase
  end

  logic             run_n, zero_n, last_n, rd_ph, wr_ph, sec_hi;
  logic [S_W-1:0]   shr;
  logic [DW-1:0]    div;
  logic [A_BIT-1:0] mask, half, t_lo, off, base, rd_b, coef_n, sector_n;
  logic [A_BIT-1:0] w, offw, sw0, sw1;

  // Decode of the upcoming state; div is a power of two so mod/div become mask/shift
  always_comb begin
    run_n    = (state_nxt == RUN);
    zero_n   = (s_nxt == '0);
    last_n   = (s_nxt == S_W'(STAGES - 1));
    shr      = zero_n ? '0 : s_nxt - 1'b1;
    div      = DW'(D) >> shr;
    mask     = A_BIT'(div - 1'b1);
    half     = A_BIT'(div >> 1);
    t_lo     = A_BIT'(t_nxt);
    rd_ph    = run_n && (t_nxt < T_W'(D));
    off      = t_lo & mask;
    base     = t_lo - off;
    sector_n = A_BIT'(t_nxt >> (S_W'(A_BIT) - shr));
    rd_b     = zero_n ? t_lo : base + ((A_BIT'(0) - off) & mask);
    coef_n   = A_BIT'(off << shr);
    wr_ph    = run_n && (t_nxt >= T_W'(WR_LAT)) && (t_nxt < T_W'(WR_LAT + D));
    w        = A_BIT'(t_nxt - T_W'(WR_LAT));
    offw     = w & mask;
    sec_hi   = (offw >= half);
    sw0      = w;
    sw1      = w;
    if (!zero_n && !last_n) begin
      if (sec_hi) sw0 = w - half;
      else        sw1 = w + half;
    end
  end

  logic [A_BIT-1:0] rd_a_q, rd_b_q, wr_a_q, wr_b_q, coef_q, stage_q, sector_q;
  logic             st_zero_q, st_last_q, sec_q, we_a_q, we_b_q, src_q, rdy_q, done_q;

  // Output registers, loaded with the decode of the state being entered
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      rd_a_q    <= '0;
      rd_b_q    <= '0;
      wr_a_q    <= '0;
      wr_b_q    <= '0;
      coef_q    <= '0;
      stage_q   <= '0;
      sector_q  <= '0;
      st_zero_q <= 1'b0;
      st_last_q <= 1'b0;
      sec_q     <= 1'b0;
      we_a_q    <= 1'b0;
      we_b_q    <= 1'b0;
      src_q     <= 1'b0;
      rdy_q     <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      rd_a_q    <= rd_ph ? t_lo : '0;
      rd_b_q    <= rd_ph ? rd_b : '0;
      coef_q    <= (rd_ph && !zero_n) ? coef_n : '0;
      sector_q  <= rd_ph ? sector_n : '0;
      wr_a_q    <= wr_ph ? sw0 : '0;
      wr_b_q    <= wr_ph ? sw1 : '0;
      stage_q   <= run_n ? A_BIT'(s_nxt) : '0;
      st_zero_q <= run_n && zero_n;
      st_last_q <= run_n && last_n;
      sec_q     <= wr_ph && sec_hi;
      we_a_q    <= wr_ph && s_nxt[0];
      we_b_q    <= wr_ph && !s_nxt[0];
      src_q     <= run_n && s_nxt[0];
      rdy_q     <= (state_nxt == IDLE);
      done_q    <= (state_nxt == DONE);
    end
  end

  assign oADDR_RD_0       = rd_a_q;
  assign oADDR_RD_2       = rd_a_q;
  assign oADDR_RD_1       = rd_b_q;
  assign oADDR_RD_3       = rd_b_q;
  assign oADDR_WR_0       = wr_a_q;
  assign oADDR_WR_1       = wr_a_q;
  assign oADDR_WR_2       = wr_b_q;
  assign oADDR_WR_3       = wr_b_q;
  assign oADDR_COEF       = coef_q;
  assign oSTAGE           = stage_q;
  assign oSECTOR          = sector_q;
  assign oST_ZERO         = st_zero_q;
  assign oST_LAST         = st_last_q;
  assign o2ND_PART_SUBSEC = sec_q;
  assign oWE_A            = we_a_q;
  assign oWE_B            = we_b_q;
  assign oSOURCE_DATA     = src_q;
  assign oRDY             = rdy_q;
  assign oDONE            = done_q;

endmodule

// File: tb/tb_fht_sequencer.sv
// Bench for fht_sequencer (A_BIT=3, WR_LAT=2): per-cycle scoreboard against an
// arithmetic reference plus hand-computed spot values.
module tb_fht_sequencer;

  localparam int D  = 8;
  localparam int ST = 5;
  localparam int L  = 11;
  localparam int WL = 2;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  typedef struct packed {
    logic [2:0] rd0, rd1, rd2, rd3, wr0, wr1, wr2, wr3, coef, stage, sector;
    logic       st_zero, st_last, second, we_a, we_b, src, rdy, done;
  } outs_t;

  logic iCLK, iRESET, iSTART, iABORT;
  logic [2:0] oADDR_RD_0, oADDR_RD_1, oADDR_RD_2, oADDR_RD_3;
  logic [2:0] oADDR_WR_0, oADDR_WR_1, oADDR_WR_2, oADDR_WR_3;
  logic [2:0] oADDR_COEF, oSTAGE, oSECTOR;
  logic oST_ZERO, oST_LAST, o2ND_PART_SUBSEC, oWE_A, oWE_B, oSOURCE_DATA, oRDY, oDONE;

  fht_sequencer #(.A_BIT(3), .WR_LAT(2)) dut (
    .iCLK(iCLK), .iRESET(iRESET), .iSTART(iSTART), .iABORT(iABORT),
    .oADDR_RD_0(oADDR_RD_0), .oADDR_RD_1(oADDR_RD_1), .oADDR_RD_2(oADDR_RD_2),
    .oADDR_RD_3(oADDR_RD_3), .oADDR_WR_0(oADDR_WR_0), .oADDR_WR_1(oADDR_WR_1),
    .oADDR_WR_2(oADDR_WR_2), .oADDR_WR_3(oADDR_WR_3), .oADDR_COEF(oADDR_COEF),
    .oSTAGE(oSTAGE), .oSECTOR(oSECTOR), .oST_ZERO(oST_ZERO), .oST_LAST(oST_LAST),
    .o2ND_PART_SUBSEC(o2ND_PART_SUBSEC), .oWE_A(oWE_A), .oWE_B(oWE_B),
    .oSOURCE_DATA(oSOURCE_DATA), .oRDY(oRDY), .oDONE(oDONE)
  );

  outs_t act;
  assign act = {oADDR_RD_0, oADDR_RD_1, oADDR_RD_2, oADDR_RD_3,
                oADDR_WR_0, oADDR_WR_1, oADDR_WR_2, oADDR_WR_3,
                oADDR_COEF, oSTAGE, oSECTOR, oST_ZERO, oST_LAST,
                o2ND_PART_SUBSEC, oWE_A, oWE_B, oSOURCE_DATA, oRDY, oDONE};

  int    n_tests = 0;
  int    n_fail  = 0;
  outs_t exp_q[$];
  int    mst = M_IDLE, ms = 0, mt = 0;

  initial begin
    iCLK = 1'b0;
    forever #5 iCLK = ~iCLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1);
  end

  // Reference outputs written straight from the arithmetic definition
  function automatic outs_t exp_of(input int st, input int s, input int t);
    outs_t e;
    int div, off, base, w, offw, sw0, sw1;
    bit sec;
    e = '0;
    e.rdy  = (st == M_IDLE);
    e.done = (st == M_DONE);
    if (st == M_RUN) begin
      e.stage   = 3'(s);
      e.st_zero = (s == 0);
      e.st_last = (s == ST - 1);
      e.src     = 1'(s % 2);
      if (s == 0)           div = D;
      else if (s == ST - 1) div = 1;
      else                  div = D >> (s - 1);
      if (t < D) begin
        off  = t % div;
        base = t - off;
        e.rd0 = 3'(t);
        e.rd2 = 3'(t);
        e.sector = 3'(t / div);
        e.rd1 = (s == 0) ? 3'(t) : 3'((base + (div - off) % div) % D);
        e.rd3 = e.rd1;
        if (s >= 1) e.coef = 3'((off * (D / div)) % D);
      end
      if (t >= WL && t < WL + D) begin
        w    = t - WL;
        offw = w % div;
        sec  = (offw >= div / 2);
        e.second = sec;
        if (s == 0 || s == ST - 1) begin
          sw0 = w; sw1 = w;
        end else if (sec) begin
          sw0 = (w - div / 2 + D) % D; sw1 = w;
        end else begin
          sw0 = w; sw1 = (w + div / 2) % D;
        end
        e.wr0 = 3'(sw0); e.wr1 = 3'(sw0);
        e.wr2 = 3'(sw1); e.wr3 = 3'(sw1);
        e.we_b = (s % 2 == 0);
        e.we_a = (s % 2 == 1);
      end
    end
    return e;
  endfunction

  task automatic model_step(input logic st, input logic ab);
    case (mst)
      M_IDLE: if (st) begin mst = M_RUN; ms = 0; mt = 0; end
      M_RUN: begin
        if (ab) begin
          mst = M_IDLE; ms = 0; mt = 0;
        end else if (mt == L - 1) begin
          if (ms == ST - 1) begin mst = M_DONE; ms = 0; end
          else ms = ms + 1;
          mt = 0;
        end else begin
          mt = mt + 1;
        end
      end
      default: begin mst = M_IDLE; ms = 0; mt = 0; end
    endcase
  endtask

  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, a, e);
    end
  endtask

  task automatic chk_outs(input string name, input outs_t e);
    n_tests++;
    if (act !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, e);
    end
  endtask

  // Monitor: outputs are presented every cycle, compare against the queued prediction
  initial begin
    outs_t e;
    forever begin
      @(posedge iCLK);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_tests++;
        if (act !== e) begin
          n_fail++;
          $display("FAIL outs@%0t: got %h expected %h", $time, act, e);
        end
      end
    end
  end

  // One clock with the given inputs; called and returns at a falling edge
  task automatic cyc(input logic st, input logic ab);
    iSTART = st;
    iABORT = ab;
    model_step(st, ab);
    exp_q.push_back(exp_of(mst, ms, mt));
    @(posedge iCLK);
    @(negedge iCLK);
  endtask

  task automatic rst_cyc();
    iSTART = 1'b0;
    iABORT = 1'b0;
    exp_q.push_back(exp_of(M_IDLE, 0, 0));
    @(posedge iCLK);
    @(negedge iCLK);
  endtask

  task automatic advance(input int s, input int t);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      if (mst == M_RUN && ms == s && mt == t) hit = 1'b1;
      else cyc(1'b0, 1'b0);
    end
  endtask

  task automatic spot();
    if (mst == M_RUN) begin
      if (ms == 0 && mt == 5) chk("rd1_s0_t5", 32'(oADDR_RD_1), 32'd5);
      if (ms == 1 && mt == 0) chk("rd1_s1_t0", 32'(oADDR_RD_1), 32'd0);
      if (ms == 1 && mt == 3) begin
        chk("rd1_s1_t3", 32'(oADDR_RD_1), 32'd5);
        chk("wr0_s1_w1", 32'(oADDR_WR_0), 32'd1);
        chk("wr2_s1_w1", 32'(oADDR_WR_2), 32'd5);
      end
      if (ms == 1 && mt == 8) begin
        chk("wr0_s1_w6", 32'(oADDR_WR_0), 32'd2);
        chk("wr2_s1_w6", 32'(oADDR_WR_2), 32'd6);
        chk("sec_s1_w6", 32'(o2ND_PART_SUBSEC), 32'd1);
      end
      if (ms == 1) chk("we_a_s1", 32'(oWE_A), (mt >= 2 && mt <= 9) ? 32'd1 : 32'd0);
      if (ms == 2 && mt == 5) begin
        chk("rd1_s2_t5", 32'(oADDR_RD_1), 32'd7);
        chk("coef_s2_t5", 32'(oADDR_COEF), 32'd2);
        chk("sector_s2_t5", 32'(oSECTOR), 32'd1);
      end
      if (ms == 4 && mt == 4) begin
        chk("wr0_s4_w2", 32'(oADDR_WR_0), 32'd2);
        chk("wr2_s4_w2", 32'(oADDR_WR_2), 32'd2);
        chk("sec_s4_w2", 32'(o2ND_PART_SUBSEC), 32'd1);
      end
    end
  endtask

  // Full run with a stray iSTART mid-run; counts RUN cycles and DONE pulses
  task automatic run_full(input bit spots);
    int run_cnt, done_cnt;
    bit fin;
    cyc(1'b1, 1'b0);
    chk("rdy_drop", 32'(oRDY), 32'd0);
    run_cnt = 0;
    done_cnt = 0;
    fin = 1'b0;
    for (int i = 0; i < 80 && !fin; i++) begin
      if (oRDY) fin = 1'b1;
      else begin
        if (oDONE) done_cnt++;
        else run_cnt++;
        if (spots) spot();
        cyc(i == 20, 1'b0);
      end
    end
    chk("run_cycles", 32'(run_cnt), 32'd55);
    chk("done_pulses", 32'(done_cnt), 32'd1);
    chk("rdy_back", 32'(oRDY), 32'd1);
  endtask

  initial begin
    iRESET = 1'b1;
    iSTART = 1'b0;
    iABORT = 1'b0;
    #1 iRESET = 1'b0;
    #1 chk_outs("reset_vals", exp_of(M_IDLE, 0, 0));
    @(negedge iCLK);
    rst_cyc();
    rst_cyc();
    iRESET = 1'b1;
    cyc(1'b0, 1'b0);

    run_full(1'b1);
    cyc(1'b0, 1'b0);

    // Abort (with a simultaneous start) at stage 3
    cyc(1'b1, 1'b0);
    advance(3, 4);
    chk("at_stage3", 32'(oSTAGE), 32'd3);
    cyc(1'b1, 1'b1);
    chk("abort_rdy", 32'(oRDY), 32'd1);
    chk("abort_done", 32'(oDONE), 32'd0);
    chk("abort_we_a", 32'(oWE_A), 32'd0);
    chk("abort_we_b", 32'(oWE_B), 32'd0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0);

    // Asynchronous reset in the middle of stage 2
    cyc(1'b1, 1'b0);
    advance(2, 6);
    chk("at_stage2", 32'(oSTAGE), 32'd2);
    iRESET = 1'b0;
    #1 chk_outs("async_reset", exp_of(M_IDLE, 0, 0));
    mst = M_IDLE; ms = 0; mt = 0;
    rst_cyc();
    iRESET = 1'b1;
    cyc(1'b0, 1'b0);
    run_full(1'b0);

    @(posedge iCLK);
    #2;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
